hamming_codec_arbiter: RTL



---
 rtl/hamming_codec_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/hamming_codec_arbiter.sv
// hamming_codec_arbiter
//
// Shares one Hamming(7,4) encode/decode datapath between two requesters.
// An encode request turns a byte into two 7-bit codewords. A decode request
// turns two codewords into a corrected byte. The codec handles the low half
// in one cycle and the high half in the next.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   reqN_valid/op/data   request from requester N (op 0 = encode, 1 = decode)
//   reqN_ready           request N accepted this cycle (combinational)
//   rsp_valid/ready      response handshake
//   rsp_id/op/data/err   response payload, held stable while rsp_valid && !rsp_ready
//   busy                 FSM is not idle
//   err_count            saturating count of corrected codewords
//   clr_count            synchronous clear of err_count (wins over increment)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. reqN_ready is only high in IDLE for the granted, valid requester. Once
// raised, rsp_valid and the rsp_* payload stay unchanged until the edge where
// rsp_ready is also high.
module hamming_codec_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req0_op,
    input  logic [13:0]      req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic             req1_op,
    input  logic [13:0]      req1_data,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_op,
    output logic [13:0]      rsp_data,
    output logic [1:0]       rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] err_count,
    input  logic             clr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               op_q, op_d;
    logic               id_q, id_d;
    logic [13:0]        data_q, data_d;
    logic [13:0]        rsp_data_q, rsp_data_d;
    logic [1:0]         rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

    logic               grant;
    logic               any_valid;
    logic               sel_hi;
    logic [3:0]         enc_nib;
    logic [6:0]         enc_cw;
    logic [6:0]         dec_in;
    logic [2:0]         syn;
    logic [6:0]         fixed_cw;
    logic [3:0]         dec_nib;
    logic               corrected;
    logic               cnt_inc;

    // Arbitration: on contention the requester that did not win last time
    // gets the grant; otherwise the single valid requester wins.
    assign any_valid = req0_valid | req1_valid;
    assign grant     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

    assign req0_ready = (state_q == IDLE) && req0_valid && (grant == 1'b0);
    assign req1_ready = (state_q == IDLE) && req1_valid && (grant == 1'b1);

    // Single codec, fed by a half-select mux on the captured operand.
    assign sel_hi  = (state_q == HI);
    assign enc_nib = sel_hi ? data_q[7:4]  : data_q[3:0];
    assign dec_in  = sel_hi ? data_q[13:7] : data_q[6:0];

    // Codeword layout {d3,d2,d1,p2,d0,p1,p0}.
    assign enc_cw = {enc_nib[3], enc_nib[2], enc_nib[1],
                     enc_nib[1] ^ enc_nib[2] ^ enc_nib[3],
                     enc_nib[0],
                     enc_nib[0] ^ enc_nib[2] ^ enc_nib[3],
                     enc_nib[0] ^ enc_nib[1] ^ enc_nib[3]};

    assign syn[0] = dec_in[0] ^ dec_in[2] ^ dec_in[4] ^ dec_in[6];
    assign syn[1] = dec_in[1] ^ dec_in[2] ^ dec_in[5] ^ dec_in[6];
    assign syn[2] = dec_in[3] ^ dec_in[4] ^ dec_in[5] ^ dec_in[6];
    assign corrected = (syn != 3'd0);

    // The syndrome is the 1-based position of the flipped bit.
    always_comb begin
        fixed_cw = dec_in;
        if (corrected) begin
            fixed_cw[syn - 3'd1] = ~dec_in[syn - 3'd1];
        end
    end

    assign dec_nib = {fixed_cw[6], fixed_cw[5], fixed_cw[4], fixed_cw[2]};

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        id_d         = id_q;
        data_d       = data_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        cnt_inc      = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d      = LO;
                    id_d         = grant;
                    last_grant_d = grant;
                    op_d         = grant ? req1_op   : req0_op;
                    data_d       = grant ? req1_data : req0_data;
                    // Clear the payload so unused bits read as zero.
                    rsp_data_d   = '0;
                    rsp_err_d    = '0;
                end
            end
            LO: begin
                if (op_q) begin
                    rsp_data_d[3:0] = dec_nib;
                    rsp_err_d[0]    = corrected;
                    cnt_inc         = corrected;
                end else begin
                    rsp_data_d[6:0] = enc_cw;
                end
                state_d = HI;
            end
            HI: begin
                if (op_q) begin
                    rsp_data_d[7:4] = dec_nib;
                    rsp_err_d[1]    = corrected;
                    cnt_inc         = corrected;
                end else begin
                    rsp_data_d[13:7] = enc_cw;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_count_d = err_count_q;
        if (clr_count) begin
            err_count_d = '0;
        end else if (cnt_inc && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= 1'b0;
            id_q         <= 1'b0;
            data_q       <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            id_q         <= id_d;
            data_q       <= data_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_op    = op_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);
    assign err_count = err_count_q;

endmodule
